cache_req_seq: RTL and testbench
================================

CACHE_REQ_SEQ -- requirements
Module: cache_req_seq

Interface
REQ-001 SHALL have parameter PROG_LEN, default 5, giving 2^PROG_LEN program entries.
REQ-002 SHALL have parameter SHADOW_LEN, default 9, giving 2^SHADOW_LEN shadow words, indexed by addr[SHADOW_LEN+1:2].
REQ-003 SHALL have parameter TIMEOUT, default 1023, the maximum number of miss cycles allowed per entry.
REQ-004 SHALL have ports: clk in 1, clock; rst in 1, reset, asynchronous, active-high.
REQ-005 SHALL have program ports: load_en in 1, load strobe; load_we in 1, 1=write op, 0=read op; load_addr in 32, byte address; load_wdata in 32, write data.
REQ-006 SHALL have control ports: start in 1, begin run; busy out 1, run in progress; done out 1, one-cycle completion pulse; timeout out 1, run aborted.
REQ-007 SHALL have cache-side ports: addr out 32; rd_req out 1; wr_req out 1; wr_data out 32; miss in 1, cache not ready/not hit; rd_data in 32, valid the cycle after a read is accepted.
REQ-008 SHALL have statistics ports: req_cnt out 32, accepted requests; miss_evt_cnt out 32, entries that saw at least one miss cycle; miss_cyc_cnt out 32, total miss cycles; err_cnt out 16, read mismatches; first_err_idx out PROG_LEN, index of the first mismatch.

Function
REQ-009 SHALL implement the states IDLE, ISSUE, RDCHK and DONE; busy=1 exactly in ISSUE and RDCHK.
REQ-010 SHALL, in IDLE with load_en=1, write {load_we,load_addr,load_wdata} at the load pointer and increment it; loads SHALL be ignored when the pointer equals 2^PROG_LEN or the state is not IDLE.
REQ-011 SHALL, on start in IDLE, clear all statistics, timeout, entry index and shadow valid bits, then enter ISSUE if the load pointer > 0, else DONE.
REQ-012 SHALL drive addr, rd_req/wr_req and wr_data from registers only, held stable for the full duration of an entry while miss=1; rd_req and wr_req SHALL never be high together.
REQ-013 SHALL treat a request as accepted on a rising edge where it is asserted and miss=0.
REQ-014 SHALL, in ISSUE, increment miss_cyc_cnt on every cycle with miss=1, and increment miss_evt_cnt once per entry on its first miss cycle.
REQ-015 SHALL, on an accepted write: store wr_data into the shadow word, set that word's valid bit, increment req_cnt, and advance to the next entry in the same state (back-to-back, zero idle cycles), or go to DONE after the last entry.
REQ-016 SHALL, on an accepted read: increment req_cnt, deassert rd_req and enter RDCHK.
REQ-017 SHALL, in RDCHK (exactly one cycle): compare rd_data with the shadow word only if the word is valid; on mismatch, increment err_cnt (saturating at 16'hFFFF) and, if it is the first error, capture first_err_idx; then go to ISSUE with the next entry, or to DONE.
REQ-018 SHALL, when one entry accumulates TIMEOUT consecutive miss cycles, drop requests, set timeout=1 and go to DONE.
REQ-019 SHALL, in DONE, assert done for one cycle with requests low, then return to IDLE; the load pointer SHALL be retained so the program can be rerun.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL hold the statistics ports stable from DONE until the next start.

Reset
REQ-022 SHALL, on rst (including mid-run), go to IDLE with all outputs 0, statistics 0, load pointer 0 and shadow valid bits cleared, and deassert requests immediately.
REQ-023 SHALL not require program or shadow data contents to be reset.

Verification
REQ-024 Load W 0x10=0xA5, R 0x10, with a cache model that misses 4 cycles on the first access then hits -> req_cnt=2, miss_evt_cnt=1, miss_cyc_cnt=4, err_cnt=0, done pulse.
REQ-025 Load 8 consecutive hitting writes -> wr_req high for 8 consecutive cycles, addresses advancing each cycle, req_cnt=8.
REQ-026 Load W 0x20=1, R 0x20, with the model returning 2 -> err_cnt=1, first_err_idx=1; a read of an unwritten word gives err_cnt unchanged.
REQ-027 Hold miss=1 permanently with TIMEOUT=15 -> timeout=1 after 15 miss cycles, done pulse, requests low.
REQ-028 Assert rst during ISSUE with miss=1 -> rd_req/wr_req 0 at once, busy=0, load pointer 0; a start with no program gives an immediate done.
REQ-029 Attempt 2^PROG_LEN+3 loads, then run -> exactly 2^PROG_LEN requests executed; start and load_en asserted during a run are ignored.

Source files
------------

// File: rtl/cache_req_seq_if.sv
// Cache-side request bus between the request sequencer (master) and the cache (slave).
interface cache_req_seq_if;
  logic [31:0] addr;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        miss;
  logic [31:0] rd_data;

  modport master (output addr, rd_req, wr_req, wr_data, input miss, rd_data);
  modport slave  (input addr, rd_req, wr_req, wr_data, output miss, rd_data);
endinterface

// File: rtl/cache_req_seq.sv
// Programmable cache request sequencer: replays a loaded list of reads/writes against a cache,
// checks read data against a shadow copy of written words and gathers miss/error statistics.
module cache_req_seq #(
  parameter int PROG_LEN   = 5,
  parameter int SHADOW_LEN = 9,
  parameter int TIMEOUT    = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_en,
  input  logic                load_we,
  input  logic [31:0]         load_addr,
  input  logic [31:0]         load_wdata,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  cache_req_seq_if.master     cache,
  output logic [31:0]         req_cnt,
  output logic [31:0]         miss_evt_cnt,
  output logic [31:0]         miss_cyc_cnt,
  output logic [15:0]         err_cnt,
  output logic [PROG_LEN-1:0] first_err_idx
);
  localparam int PN    = 2 ** PROG_LEN;
  localparam int SN    = 2 ** SHADOW_LEN;
  localparam int PTR_W = PROG_LEN + 1;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RDCHK = 2'd2, DONE = 2'd3} state_t;
  state_t state_r, state_n;

  logic                  prog_we_m   [PN];
  logic [31:0]           prog_addr_m [PN];
  logic [31:0]           prog_data_m [PN];
  logic [31:0]           shadow_m    [SN];
  logic [SN-1:0]         shadow_vld_r;
  logic [PTR_W-1:0]      load_ptr_r;
  logic [PROG_LEN-1:0]   idx_r, nidx_s;
  logic [31:0]           addr_r, wr_data_r;
  logic                  rd_req_r, wr_req_r;
  logic                  busy_r, done_r, timeout_r;
  logic [31:0]           req_cnt_r, miss_evt_r, miss_cyc_r, miss_run_r;
  logic [15:0]           err_cnt_r;
  logic [PROG_LEN-1:0]   first_err_r;
  logic [SHADOW_LEN-1:0] sidx_s;
  logic                  load_ok_s, last_s, tmo_s, fetch_s, mismatch_s;

  // Next-state decode plus the strobes shared by the datapath.
  always_comb begin
    state_n    = state_r;
    fetch_s    = 1'b0;
    nidx_s     = idx_r + PROG_LEN'(1);
    sidx_s     = addr_r[SHADOW_LEN+1:2];
    load_ok_s  = (state_r == IDLE) && load_en && (load_ptr_r != PTR_W'(PN));
    last_s     = (PTR_W'(idx_r) + PTR_W'(1)) == load_ptr_r;
    tmo_s      = (miss_run_r == TMO_LAST);
    mismatch_s = shadow_vld_r[sidx_s] && (cache.rd_data != shadow_m[sidx_s]);
    case (state_r)
      IDLE: begin
        nidx_s = PROG_LEN'(0);
        if (start) begin
          if (load_ptr_r != PTR_W'(0)) begin
            state_n = ISSUE;
            fetch_s = 1'b1;
          end else begin
            state_n = DONE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        if (cache.miss) begin
          if (tmo_s) state_n = DONE;
          else       state_n = ISSUE;
        end else if (wr_req_r) begin
          if (last_s) begin
            state_n = DONE;
          end else begin
            state_n = ISSUE;
            fetch_s = 1'b1;
          end
        end else begin
          state_n = RDCHK;
        end
      end
      RDCHK: begin
        if (last_s) begin
          state_n = DONE;
        end else begin
          state_n = ISSUE;
          fetch_s = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Program and shadow data storage; contents are qualified by the pointer / valid bits.
  always_ff @(posedge clk) begin
    if (load_ok_s) begin
      prog_we_m[load_ptr_r[PROG_LEN-1:0]]   <= load_we;
      prog_addr_m[load_ptr_r[PROG_LEN-1:0]] <= load_addr;
      prog_data_m[load_ptr_r[PROG_LEN-1:0]] <= load_wdata;
    end
    if ((state_r == ISSUE) && !cache.miss && wr_req_r) begin
      shadow_m[sidx_s] <= wr_data_r;
    end
  end

  // State register, request outputs and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      load_ptr_r   <= PTR_W'(0);
      idx_r        <= PROG_LEN'(0);
      addr_r       <= 32'd0;
      wr_data_r    <= 32'd0;
      rd_req_r     <= 1'b0;
      wr_req_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      timeout_r    <= 1'b0;
      req_cnt_r    <= 32'd0;
      miss_evt_r   <= 32'd0;
      miss_cyc_r   <= 32'd0;
      miss_run_r   <= 32'd0;
      err_cnt_r    <= 16'd0;
      first_err_r  <= PROG_LEN'(0);
      shadow_vld_r <= '0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n == ISSUE) || (state_n == RDCHK);
      done_r  <= (state_n == DONE);
      if (load_ok_s) load_ptr_r <= load_ptr_r + PTR_W'(1);
      if (fetch_s) begin
        idx_r      <= nidx_s;
        addr_r     <= prog_addr_m[nidx_s];
        wr_data_r  <= prog_data_m[nidx_s];
        wr_req_r   <= prog_we_m[nidx_s];
        rd_req_r   <= ~prog_we_m[nidx_s];
        miss_run_r <= 32'd0;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            idx_r        <= PROG_LEN'(0);
            timeout_r    <= 1'b0;
            req_cnt_r    <= 32'd0;
            miss_evt_r   <= 32'd0;
            miss_cyc_r   <= 32'd0;
            err_cnt_r    <= 16'd0;
            first_err_r  <= PROG_LEN'(0);
            shadow_vld_r <= '0;
          end
        end
        ISSUE: begin
          if (cache.miss) begin
            miss_cyc_r <= miss_cyc_r + 32'd1;
            if (miss_run_r == 32'd0) miss_evt_r <= miss_evt_r + 32'd1;
            miss_run_r <= miss_run_r + 32'd1;
            if (tmo_s) begin
              rd_req_r  <= 1'b0;
              wr_req_r  <= 1'b0;
              timeout_r <= 1'b1;
            end
          end else begin
            req_cnt_r <= req_cnt_r + 32'd1;
            if (wr_req_r) begin
              shadow_vld_r[sidx_s] <= 1'b1;
              if (last_s) wr_req_r <= 1'b0;
            end else begin
              rd_req_r <= 1'b0;
            end
          end
        end
        RDCHK: begin
          // Only the first error in a run records its entry index.
          if (mismatch_s) begin
            if (err_cnt_r != 16'hFFFF) err_cnt_r <= err_cnt_r + 16'd1;
            if (err_cnt_r == 16'd0) first_err_r <= idx_r;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign cache.addr    = addr_r;
  assign cache.rd_req  = rd_req_r;
  assign cache.wr_req  = wr_req_r;
  assign cache.wr_data = wr_data_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign timeout       = timeout_r;
  assign req_cnt       = req_cnt_r;
  assign miss_evt_cnt  = miss_evt_r;
  assign miss_cyc_cnt  = miss_cyc_r;
  assign err_cnt       = err_cnt_r;
  assign first_err_idx = first_err_r;
endmodule

// File: tb/tb_cache_req_seq.sv
// Bench for cache_req_seq: a cache responder driven by per-entry miss/read-data plans and a
// program-level reference model of the expected statistics and run length.
module tb_cache_req_seq;
  localparam int PL  = 5;
  localparam int SL  = 9;
  localparam int TMO = 15;
  localparam int PN  = 32;

  logic clk = 1'b0, rst = 1'b1;
  logic load_en = 1'b0, load_we = 1'b0, start = 1'b0;
  logic [31:0] load_addr = 32'd0, load_wdata = 32'd0;
  logic busy, done, timeout;
  logic [31:0] req_cnt, miss_evt_cnt, miss_cyc_cnt;
  logic [15:0] err_cnt;
  logic [PL-1:0] first_err_idx;

  cache_req_seq_if cache();

  cache_req_seq #(.PROG_LEN(PL), .SHADOW_LEN(SL), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_we(load_we), .load_addr(load_addr),
    .load_wdata(load_wdata), .start(start), .busy(busy), .done(done), .timeout(timeout),
    .cache(cache), .req_cnt(req_cnt), .miss_evt_cnt(miss_evt_cnt), .miss_cyc_cnt(miss_cyc_cnt),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  // Program as loaded, plus how the cache answers each entry's request.
  logic        tb_we   [PN];
  logic [31:0] tb_addr [PN];
  logic [31:0] tb_data [PN];
  logic [31:0] rd_plan [PN];
  int          miss_plan [PN];
  int          tb_n = 0;
  bit          miss_always = 1'b0;

  int acc_idx = 0, left = 0;
  bit armed = 1'b0, pend_acc = 1'b0;
  int n_pass = 0, n_chk = 0;
  int g_busy, g_maxstreak, g_adv_bad, g_both;

  // Cache responder: holds miss for miss_plan[k] cycles on the k-th request, then accepts it.
  always @(negedge clk) begin
    if (rst) begin
      acc_idx = 0; armed = 1'b0; pend_acc = 1'b0; left = 0;
      cache.miss = 1'b0; cache.rd_data = 32'd0;
    end else begin
      if (pend_acc) begin acc_idx++; armed = 1'b0; pend_acc = 1'b0; end
      if (!busy && !cache.rd_req && !cache.wr_req) acc_idx = 0;
      cache.miss = miss_always;
      if ((cache.rd_req || cache.wr_req) && !miss_always) begin
        if (!armed) begin left = miss_plan[acc_idx % PN]; armed = 1'b1; end
        if (left > 0) begin cache.miss = 1'b1; left--; end
        else begin
          pend_acc = 1'b1;
          if (cache.rd_req) cache.rd_data = rd_plan[acc_idx % PN];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    tb_n = 0;
  endtask

  task automatic load_one(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); load_en = 1'b1; load_we = we; load_addr = a; load_wdata = d;
    @(negedge clk); load_en = 1'b0;
    if (tb_n < PN) begin tb_we[tb_n] = we; tb_addr[tb_n] = a; tb_data[tb_n] = d; tb_n++; end
  endtask

  task automatic run(input bit disturb);
    int e_req, e_evt, e_cyc, e_err, e_fi, e_busy, cycles, streak;
    bit e_tmo;
    logic [31:0] sh [int];
    logic [31:0] prev_a;
    e_req = 0; e_evt = 0; e_cyc = 0; e_err = 0; e_fi = 0; e_busy = 0; e_tmo = 1'b0;
    if (miss_always && tb_n > 0) begin
      e_evt = 1; e_cyc = TMO; e_busy = TMO; e_tmo = 1'b1;
    end else begin
      for (int i = 0; i < tb_n; i++) begin
        int k;
        k = int'(tb_addr[i][SL+1:2]);
        e_req++;
        e_cyc  += miss_plan[i];
        e_busy += miss_plan[i] + 1;
        if (miss_plan[i] > 0) e_evt++;
        if (tb_we[i]) sh[k] = tb_data[i];
        else begin
          e_busy++;
          if (sh.exists(k) && sh[k] != rd_plan[i]) begin
            if (e_err == 0) e_fi = i;
            e_err++;
          end
        end
      end
    end
    g_busy = 0; g_maxstreak = 0; g_adv_bad = 0; g_both = 0; streak = 0; prev_a = 32'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 0;
    while (!done && cycles < 3000) begin
      if (busy) g_busy++;
      if (cache.rd_req && cache.wr_req) g_both++;
      if (cache.wr_req) begin
        if (streak > 0 && cache.addr != prev_a + 32'd4) g_adv_bad++;
        streak++; prev_a = cache.addr;
        if (streak > g_maxstreak) g_maxstreak = streak;
      end else streak = 0;
      if (disturb && cycles == 2) begin start = 1'b1; load_en = 1'b1; load_we = 1'b1; end
      if (disturb && cycles == 3) begin start = 1'b0; load_en = 1'b0; end
      @(negedge clk); cycles++;
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("req_low_at_done", {30'd0, cache.rd_req, cache.wr_req}, 32'd0);
    check("busy_cycles", 32'(g_busy), 32'(e_busy));
    check("rd_wr_exclusive", 32'(g_both), 32'd0);
    check("req_cnt", req_cnt, 32'(e_req));
    check("miss_evt_cnt", miss_evt_cnt, 32'(e_evt));
    check("miss_cyc_cnt", miss_cyc_cnt, 32'(e_cyc));
    check("err_cnt", 32'(err_cnt), 32'(e_err));
    check("timeout", 32'(timeout), 32'(e_tmo));
    if (e_err > 0) check("first_err_idx", 32'(first_err_idx), 32'(e_fi));
    repeat (2) @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("stats_hold", req_cnt, 32'(e_req));
  endtask

  initial begin
    for (int i = 0; i < PN; i++) begin miss_plan[i] = 0; rd_plan[i] = 32'd0; end

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_req", {30'd0, cache.rd_req, cache.wr_req}, 32'd0);
    check("rst_stats", req_cnt | miss_evt_cnt | miss_cyc_cnt | 32'(err_cnt), 32'd0);
    rst = 1'b0;

    // Write then read back, first access misses for 4 cycles
    do_reset();
    load_one(1'b1, 32'h10, 32'hA5);
    load_one(1'b0, 32'h10, 32'h0);
    miss_plan[0] = 4; miss_plan[1] = 0; rd_plan[1] = 32'hA5;
    run(1'b0);

    // Eight back-to-back hitting writes
    do_reset();
    for (int i = 0; i < 8; i++) begin
      load_one(1'b1, 32'h100 + 32'(4 * i), 32'(i));
      miss_plan[i] = 0;
    end
    run(1'b0);
    check("wr_streak", 32'(g_maxstreak), 32'd8);
    check("wr_addr_advance", 32'(g_adv_bad), 32'd0);

    // Read mismatch and a read of an unwritten word
    do_reset();
    load_one(1'b1, 32'h20, 32'h1);
    load_one(1'b0, 32'h20, 32'h0);
    load_one(1'b0, 32'h40, 32'h0);
    miss_plan[0] = 0; miss_plan[1] = 0; miss_plan[2] = 0;
    rd_plan[1] = 32'h2; rd_plan[2] = 32'h7;
    run(1'b0);
    check("err_unwritten", 32'(err_cnt), 32'd1);
    check("first_err_one", 32'(first_err_idx), 32'd1);

    // Permanent miss runs into the timeout
    do_reset();
    load_one(1'b0, 32'h0, 32'h0);
    miss_always = 1'b1;
    run(1'b0);
    miss_always = 1'b0;

    // Reset in the middle of a missing write, then an empty program
    do_reset();
    for (int i = 0; i < 3; i++) load_one(1'b1, 32'h200 + 32'(4 * i), 32'(i));
    miss_always = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_wr_req", 32'(cache.wr_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_req_now", {30'd0, cache.rd_req, cache.wr_req}, 32'd0);
    check("rst_busy_now", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0; miss_always = 1'b0; tb_n = 0;
    run(1'b0);

    // Overfill the program memory
    do_reset();
    for (int i = 0; i < PN + 3; i++) begin
      load_one(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
      if (i < PN) begin miss_plan[i] = $urandom_range(0, 2); rd_plan[i] = $urandom; end
    end
    run(1'b0);
    check("req_cap", req_cnt, 32'd32);

    // Start/load during a run are ignored; the program reruns unchanged
    do_reset();
    for (int i = 0; i < 3; i++) begin
      load_one(1'b1, 32'h300 + 32'(4 * i), $urandom);
      miss_plan[i] = 3;
    end
    run(1'b1);
    run(1'b0);

    // Randomized programs over a small pool of shadow words
    for (int r = 0; r < 6; r++) begin
      logic [31:0] lastw [int];
      int n;
      lastw.delete();
      do_reset();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        int w;
        logic we;
        logic [31:0] a, d;
        w  = $urandom_range(0, 7);
        we = 1'($urandom_range(0, 1));
        a  = ($urandom & 32'hFFFF_F800) | 32'(w << 2);
        d  = $urandom;
        load_one(we, a, d);
        miss_plan[i] = $urandom_range(0, 4);
        if (we) lastw[w] = d;
        else if (lastw.exists(w) && $urandom_range(0, 1) == 1) rd_plan[i] = lastw[w];
        else rd_plan[i] = $urandom;
      end
      run(1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
